// File: rtl/link_pkg.sv
// link_pkg: shared types and constants for the Link controller slice.
//   state_t : FSM state encoding for link_ctrl
//   dir_t   : move direction codes (UP=00, DOWN=01, LEFT=10, RIGHT=11)
//   cmd_t   : one-hot command bundle driven to the character block
//   Map geometry and spawn point constants, plus the state->command decode.
package link_pkg;

  typedef enum logic [3:0] {
    S_BOOT,
    S_INIT,
    S_DRAW,
    S_WAIT,
    S_DECIDE,
    S_ATTACK,
    S_MV_UP,
    S_MV_DOWN,
    S_MV_LEFT,
    S_MV_RIGHT
  } state_t;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  localparam int unsigned MAP_W      = 256;
  localparam int unsigned MAP_H      = 176;
  localparam int unsigned SPRITE_DIM = 16;
  localparam logic [7:0]  INIT_X     = 8'd127;
  localparam logic [7:0]  INIT_Y     = 8'd88;
  localparam logic [7:0]  X_MAX      = 8'(MAP_W - SPRITE_DIM);
  localparam logic [7:0]  Y_MAX      = 8'(MAP_H - SPRITE_DIM);

  typedef struct packed {
    logic init;
    logic idle;
    logic attack;
    logic move_up;
    logic move_down;
    logic move_left;
    logic move_right;
    logic draw_char;
  } cmd_t;

  function automatic cmd_t decode_cmd(input state_t s);
    cmd_t c;
    c = '0;
    case (s)
      S_INIT:     c.init       = ON;
      S_DRAW:     c.draw_char  = ON;
      S_WAIT:     c.idle       = ON;
      S_ATTACK:   c.attack     = ON;
      S_MV_UP:    c.move_up    = ON;
      S_MV_DOWN:  c.move_down  = ON;
      S_MV_LEFT:  c.move_left  = ON;
      S_MV_RIGHT: c.move_right = ON;
      default:    c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/link_ctrl_key_sync.sv
// key_sync: two-flop synchroniser for one raw push-button, plus a registered
// one-cycle rising-edge pulse.
//   clock, reset : system clock, async active-high reset
//   raw          : asynchronous button level
//   level        : synchronised level
//   rise         : one-cycle pulse after each synchronised 0->1 transition
module key_sync (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic s1, s2, prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      prev <= s2;
      rise <= s2 & ~prev;
    end
  end

  assign level = s2;

endmodule

// File: rtl/link_ctrl.sv
// link_ctrl: control FSM for the Link character datapath.
// Synchronises the buttons, paces actions on frame_tick, issues one-hot
// command strobes and keeps a shadow sprite position clamped to the map.
//   clock, reset          : system clock, async active-high reset
//   key_*                 : raw buttons (async)
//   frame_tick            : one-cycle pulse per video frame
//   draw_done             : character block finished drawing
//   init..draw_char       : registered one-hot commands
//   pos_x, pos_y          : shadow sprite top-left position
//   draw_err              : sticky draw watchdog error
// Optional: define LINK_CTRL_WDT_EN to enable the draw_done watchdog
// (DRAW_TIMEOUT cycles); otherwise draw_err is tied low.
module link_ctrl
  import link_pkg::*;
#(
  parameter int unsigned MOVE_PERIOD   = 1,
  parameter int unsigned ATTACK_FRAMES = 16,
  parameter int unsigned DRAW_TIMEOUT  = 4096
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_attack,
  input  logic       frame_tick,
  input  logic       draw_done,
  output logic       init,
  output logic       idle,
  output logic       attack,
  output logic       move_up,
  output logic       move_down,
  output logic       move_left,
  output logic       move_right,
  output logic       draw_char,
  output logic [7:0] pos_x,
  output logic [7:0] pos_y,
  output logic       draw_err
);

  logic       up_lvl, down_lvl, left_lvl, right_lvl, atk_lvl;
  logic [4:0] rise;
  logic       unused_sync;

  key_sync u_up    (.clock(clock), .reset(reset), .raw(key_up),     .level(up_lvl),    .rise(rise[0]));
  key_sync u_down  (.clock(clock), .reset(reset), .raw(key_down),   .level(down_lvl),  .rise(rise[1]));
  key_sync u_left  (.clock(clock), .reset(reset), .raw(key_left),   .level(left_lvl),  .rise(rise[2]));
  key_sync u_right (.clock(clock), .reset(reset), .raw(key_right),  .level(right_lvl), .rise(rise[3]));
  key_sync u_atk   (.clock(clock), .reset(reset), .raw(key_attack), .level(atk_lvl),   .rise(rise[4]));

  assign unused_sync = ^{rise[3:0], atk_lvl};

  state_t     state, state_n;
  cmd_t       cmd, cmd_n;
  logic [7:0] pos_x_n, pos_y_n;
  logic [7:0] atk_lock, atk_lock_n;
  logic       atk_pend, atk_pend_n;
  logic       tick_pend, tick_pend_n;
  logic [3:0] move_div, move_div_n;
  logic [3:0] move_div_inc;
  logic       up_ok, down_ok, left_ok, right_ok;
  logic       draw_timeout;

`ifdef LINK_CTRL_WDT_EN
  logic [15:0] wdt, wdt_n;
  logic        err, err_n;
  assign draw_timeout = (wdt == 16'(DRAW_TIMEOUT - 1));
  assign draw_err     = err;
`else
  localparam int unsigned unused_draw_timeout = DRAW_TIMEOUT;
  assign draw_timeout = 1'b0;
  assign draw_err     = 1'b0;
`endif

  // Blocked directions behave as if the key were released.
  assign up_ok    = up_lvl    && (pos_y != 8'd0);
  assign down_ok  = down_lvl  && (pos_y != Y_MAX);
  assign left_ok  = left_lvl  && (pos_x != 8'd0);
  assign right_ok = right_lvl && (pos_x != X_MAX);
  assign move_div_inc = move_div + 4'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_BOOT;
      cmd       <= '0;
      pos_x     <= '0;
      pos_y     <= '0;
      atk_lock  <= '0;
      atk_pend  <= 1'b0;
      tick_pend <= 1'b0;
      move_div  <= '0;
`ifdef LINK_CTRL_WDT_EN
      wdt       <= '0;
      err       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cmd       <= cmd_n;
      pos_x     <= pos_x_n;
      pos_y     <= pos_y_n;
      atk_lock  <= atk_lock_n;
      atk_pend  <= atk_pend_n;
      tick_pend <= tick_pend_n;
      move_div  <= move_div_n;
`ifdef LINK_CTRL_WDT_EN
      wdt       <= wdt_n;
      err       <= err_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    pos_x_n    = pos_x;
    pos_y_n    = pos_y;
    atk_lock_n = atk_lock;
    move_div_n = move_div;
    // Edges seen while locked are dropped rather than queued.
    atk_pend_n = atk_pend | (rise[4] & (atk_lock == 8'd0));
    // Single-entry tick memory: consumed by S_WAIT, never accumulates.
    tick_pend_n = (state == S_WAIT) ? 1'b0 : (tick_pend | frame_tick);
`ifdef LINK_CTRL_WDT_EN
    wdt_n = (state == S_DRAW) ? wdt + 16'd1 : '0;
    err_n = err;
`endif
    case (state)
      S_BOOT: state_n = S_INIT;
      S_INIT: begin
        pos_x_n = INIT_X;
        pos_y_n = INIT_Y;
        state_n = S_DRAW;
      end
      S_DRAW: begin
        if (draw_done) begin
          state_n = S_WAIT;
        end else if (draw_timeout) begin
          state_n = S_WAIT;
`ifdef LINK_CTRL_WDT_EN
          err_n   = 1'b1;
`endif
        end
      end
      S_WAIT: if (frame_tick || tick_pend) state_n = S_DECIDE;
      S_DECIDE: begin
        state_n = S_WAIT;
        if (atk_lock != 8'd0) begin
          atk_lock_n = atk_lock - 8'd1;
          atk_pend_n = 1'b0;
          state_n    = S_ATTACK;
        end else if (atk_pend) begin
          atk_lock_n = 8'(ATTACK_FRAMES - 1);
          atk_pend_n = 1'b0;
          state_n    = S_ATTACK;
        end else if (move_div_inc == 4'(MOVE_PERIOD)) begin
          move_div_n = '0;
          if (up_ok) begin
            pos_y_n = pos_y - 8'd1;
            state_n = S_MV_UP;
          end else if (down_ok) begin
            pos_y_n = pos_y + 8'd1;
            state_n = S_MV_DOWN;
          end else if (left_ok) begin
            pos_x_n = pos_x - 8'd1;
            state_n = S_MV_LEFT;
          end else if (right_ok) begin
            pos_x_n = pos_x + 8'd1;
            state_n = S_MV_RIGHT;
          end
        end else begin
          move_div_n = move_div_inc;
        end
      end
      S_ATTACK, S_MV_UP, S_MV_DOWN, S_MV_LEFT, S_MV_RIGHT: state_n = S_DRAW;
      default: state_n = S_BOOT;
    endcase
  end

  // Commands are registered from the next state so they align with the
  // state register while still coming straight from flops.
  always_comb begin
    cmd_n = decode_cmd(state_n);
  end

  assign init       = cmd.init;
  assign idle       = cmd.idle;
  assign attack     = cmd.attack;
  assign move_up    = cmd.move_up;
  assign move_down  = cmd.move_down;
  assign move_left  = cmd.move_left;
  assign move_right = cmd.move_right;
  assign draw_char  = cmd.draw_char;

endmodule

// File: tb/tb_link_ctrl.sv
// tb_link_ctrl: directed self-checking bench for link_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_link_ctrl;

`ifdef LINK_CTRL_WDT_EN
  localparam int unsigned DT = 100;
`else
  localparam int unsigned DT = 4096;
`endif

  localparam logic [7:0] C_NONE = 8'h00;
  localparam logic [7:0] C_INIT = 8'h80;
  localparam logic [7:0] C_IDLE = 8'h40;
  localparam logic [7:0] C_ATK  = 8'h20;
  localparam logic [7:0] C_UP   = 8'h10;
  localparam logic [7:0] C_LT   = 8'h04;
  localparam logic [7:0] C_RT   = 8'h02;
  localparam logic [7:0] C_DRAW = 8'h01;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0, key_attack = 1'b0;
  logic frame_tick = 1'b0, draw_done = 1'b0;
  logic init, idle, attack, move_up, move_down, move_left, move_right, draw_char;
  logic [7:0] pos_x, pos_y;
  logic draw_err;
  logic [7:0] cmd;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  assign cmd = {init, idle, attack, move_up, move_down, move_left, move_right, draw_char};

  link_ctrl #(
    .MOVE_PERIOD(1),
    .ATTACK_FRAMES(16),
    .DRAW_TIMEOUT(DT)
  ) dut (
    .clock(clock), .reset(reset),
    .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .key_attack(key_attack),
    .frame_tick(frame_tick), .draw_done(draw_done),
    .init(init), .idle(idle), .attack(attack),
    .move_up(move_up), .move_down(move_down),
    .move_left(move_left), .move_right(move_right),
    .draw_char(draw_char), .pos_x(pos_x), .pos_y(pos_y),
    .draw_err(draw_err)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cmd(input string tag, input logic [7:0] exp);
    check(tag, {8'h00, cmd}, {8'h00, exp});
  endtask

  task automatic check_pos(input string tag, input logic [7:0] x, input logic [7:0] y);
    check(tag, {pos_x, pos_y}, {x, y});
  endtask

  // Handshake the current draw; controller must be idle next cycle.
  task automatic ack(input string tag);
    draw_done = 1'b1;
    step();
    draw_done = 1'b0;
    check_cmd({tag, "_ack_idle"}, C_IDLE);
  endtask

  // Called with the controller in S_DECIDE: expect an action (then its draw) or a return to idle.
  task automatic after_decide(input string tag, input logic [7:0] mask, input logic [7:0] x, input logic [7:0] y);
    step();
    check_cmd({tag, "_act"}, mask);
    check_pos({tag, "_pos"}, x, y);
    if (mask != C_IDLE) begin
      step();
      check_cmd({tag, "_draw"}, C_DRAW);
      ack(tag);
    end
  endtask

  task automatic tick_act(input string tag, input logic [7:0] mask, input logic [7:0] x, input logic [7:0] y);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check_cmd({tag, "_decide"}, C_NONE);
    after_decide(tag, mask, x, y);
  endtask

  initial begin
    int n;

    // Reset state
    step(3);
    check_cmd("rst_cmd", C_NONE);
    check_pos("rst_pos", 8'd0, 8'd0);
    check("rst_err", {15'd0, draw_err}, 16'd0);

    // Boot: one BOOT cycle, one INIT cycle, then draw
    @(posedge clock);
    #1 reset = 1'b0;
    step();
    check_cmd("boot", C_NONE);
    step();
    check_cmd("init", C_INIT);
    step();
    check_cmd("first_draw", C_DRAW);
    check_pos("init_pos", 8'd127, 8'd88);
    step(63);
    check_cmd("draw_held", C_DRAW);
    ack("boot");
    check("boot_err", {15'd0, draw_err}, 16'd0);

    // Up moves
    key_up = 1'b1;
    step(3);
    tick_act("up1", C_UP, 8'd127, 8'd87);
    tick_act("up2", C_UP, 8'd127, 8'd86);
    key_up = 1'b0;
    step(3);

    // Walk to the left edge, then confirm it blocks
    key_left = 1'b1;
    step(3);
    for (int i = 1; i <= 127; i++) tick_act("left", C_LT, 8'(127 - i), 8'd86);
    tick_act("left_blk1", C_IDLE, 8'd0, 8'd86);
    tick_act("left_blk2", C_IDLE, 8'd0, 8'd86);

    // Attack lock with right held; a re-press during the lock is dropped
    key_left = 1'b0;
    key_right = 1'b1;
    key_attack = 1'b1;
    step(5);
    for (int i = 1; i <= 16; i++) begin
      tick_act("attack", C_ATK, 8'd0, 8'd86);
      if (i == 5) begin
        key_attack = 1'b0;
        step(3);
        key_attack = 1'b1;
        step(5);
      end
    end
    tick_act("resume", C_RT, 8'd1, 8'd86);
    key_attack = 1'b0;

    // One tick during a draw is remembered
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check_cmd("pd_decide", C_NONE);
    step();
    check_cmd("pd_act", C_RT);
    check_pos("pd_pos", 8'd2, 8'd86);
    step();
    check_cmd("pd_draw", C_DRAW);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step(3);
    ack("pend");
    step();
    check_cmd("pend_decide", C_NONE);
    step();
    check_cmd("pend_act", C_RT);
    check_pos("pend_pos", 8'd3, 8'd86);
    step();
    check_cmd("pend_draw", C_DRAW);

    // Two ticks during one draw yield a single action
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step(2);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step(2);
    ack("dbl");
    step();
    check_cmd("dbl_decide", C_NONE);
    after_decide("dbl", C_RT, 8'd4, 8'd86);
    step(3);
    check_cmd("dbl_no_second", C_IDLE);
    check_pos("dbl_pos", 8'd4, 8'd86);

    // Draw without draw_done
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    check_cmd("wd_act", C_RT);
    step();
    check_cmd("wd_draw", C_DRAW);
    n = 1;
`ifdef LINK_CTRL_WDT_EN
    for (int k = 0; k < 200; k++) begin
      step();
      if (draw_char !== 1'b1) break;
      n++;
    end
    check("wdt_len", 16'(n), 16'd100);
    check_cmd("wdt_idle", C_IDLE);
    check("wdt_err", {15'd0, draw_err}, 16'd1);
    step(3);
    tick_act("wdt_next", C_RT, 8'd6, 8'd86);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step(2);
    check_cmd("wdt_draw2", C_DRAW);
    step(5);
    check("wdt_sticky", {15'd0, draw_err}, 16'd1);
`else
    step(20);
    check_cmd("nowdt_wait", C_DRAW);
    check("nowdt_err", {15'd0, draw_err}, 16'd0);
`endif

    // Asynchronous reset mid-draw
    reset = 1'b1;
    #1;
    check_cmd("arst_cmd", C_NONE);
    check("arst_err", {15'd0, draw_err}, 16'd0);
    check_pos("arst_pos", 8'd0, 8'd0);
    key_right = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
